// File: rtl/example_apb_regs.sv
// rtl/example_apb_regs.sv - APB4 slave for the example register bank
// Bus setup fields are latched so a new SETUP may overlap the completing access.
package example_sv_pkg;
  localparam int addr_width = 3;

  typedef struct packed {
    logic [19:0] reg7;
    logic [31:0] reg6;
    logic [31:0] reg5;
    logic [3:0]  reg4;
    logic [7:0]  reg3;
    logic [5:0]  reg2;
    logic [31:0] reg1;
    logic [31:0] reg0;
  } example_struct_type;

  localparam logic [31:0] reg0ResetVal = 32'h0;
  localparam logic [31:0] reg1ResetVal = 32'h1;
  localparam logic [5:0]  reg2ResetVal = 6'h01;
  localparam logic [7:0]  reg3ResetVal = 8'h1;
  localparam logic [3:0]  reg4ResetVal = 4'hC;
  localparam logic [19:0] reg7ResetVal = 20'h00000;

  function automatic logic [31:0] read_example(input example_struct_type r,
                                               input logic [addr_width-1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0:    v = r.reg0;
      3'd1:    v = r.reg1;
      3'd2:    v = {26'd0, r.reg2};
      3'd3:    v = {24'd0, r.reg3};
      3'd4:    v = {28'd0, r.reg4};
      3'd5:    v = r.reg5;
      3'd6:    v = r.reg6;
      default: v = {12'd0, r.reg7};
    endcase
    return v;
  endfunction

  function automatic example_struct_type write_example(input logic [31:0] d,
                                                       input logic [addr_width-1:0] a,
                                                       input example_struct_type r);
    example_struct_type n;
    n = r;
    case (a)
      3'd0:    n.reg0 = d;
      3'd1:    n.reg1 = d;
      3'd2:    n.reg2 = d[5:0];
      3'd3:    n.reg3 = d[7:0];
      3'd4:    n.reg4 = d[3:0];
      3'd5:    n.reg5 = d;
      3'd6:    n.reg6 = d;
      default: n.reg7 = d[19:0];
    endcase
    return n;
  endfunction
endpackage

module example_apb_regs
  import example_sv_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [addr_width+1:0]   paddr,
  input  logic [31:0]             pwdata,
  input  logic [3:0]              pstrb,
  output logic [31:0]             prdata,
  output logic                    pready,
  output logic                    pslverr,
  output example_struct_type      regs,
  output logic [7:0]              wr_pulse,
  output logic [7:0]              rd_pulse,
  input  logic                    hw_reg6_we,
  input  logic [31:0]             hw_reg6_data
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} stateType;

  localparam logic [1:0] waitLoad = 2'(WAIT_STATES);

  stateType           state, stateNext;
  logic [1:0]         waitCnt, waitCntNext;
  logic [2:0]         reqAddr, reqAddrNext;
  logic               reqWrite, reqWriteNext;
  logic [31:0]        reqWdata, reqWdataNext;
  logic [3:0]         reqStrb, reqStrbNext;
  example_struct_type regsNext;
  logic               preadyNext;
  logic [31:0]        prdataNext;
  logic [7:0]         wrPulseNext, rdPulseNext;
  logic [31:0]        curVal, merged;
  logic               newSetup, capture;
  logic               unusedAddrBits;

  assign newSetup       = psel && !penable;
  assign pslverr        = 1'b0;
  assign unusedAddrBits = ^paddr[1:0];

  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    reqAddrNext  = reqAddr;
    reqWriteNext = reqWrite;
    reqWdataNext = reqWdata;
    reqStrbNext  = reqStrb;
    regsNext     = regs;
    wrPulseNext  = '0;
    rdPulseNext  = '0;
    capture      = 1'b0;
    curVal       = read_example(regs, reqAddr);
    merged       = curVal;

    case (state)
      IDLE: begin
        if (newSetup) begin
          stateNext = SETUP;
          capture   = 1'b1;
        end
      end
      SETUP: begin
        stateNext   = ACCESS;
        waitCntNext = waitLoad;
      end
      ACCESS: begin
        if (pready) begin
          if (newSetup) begin
            stateNext = SETUP;
            capture   = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end else if (!psel) begin
          stateNext = IDLE;
        end else begin
          waitCntNext = waitCnt - 2'd1;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (capture) begin
      reqAddrNext  = paddr[4:2];
      reqWriteNext = pwrite;
      reqWdataNext = pwdata;
      reqStrbNext  = pstrb;
    end

    // Hardware load first so a same-cycle bus write to reg6 overrides it.
    if (hw_reg6_we) begin
      regsNext.reg6 = hw_reg6_data;
    end

    if (pready) begin
      if (reqWrite) begin
        for (int k = 0; k < 4; k++) begin
          merged[8*k +: 8] = reqStrb[k] ? reqWdata[8*k +: 8] : curVal[8*k +: 8];
        end
        regsNext    = write_example(merged, reqAddr, regsNext);
        wrPulseNext = 8'b1 << reqAddr;
      end else begin
        rdPulseNext = 8'b1 << reqAddr;
      end
    end

    preadyNext = (stateNext == ACCESS) && (waitCntNext == 2'd0);
    prdataNext = (preadyNext && !reqWrite) ? read_example(regsNext, reqAddr) : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= '0;
      reqAddr   <= '0;
      reqWrite  <= 1'b0;
      reqWdata  <= '0;
      reqStrb   <= '0;
      pready    <= 1'b0;
      prdata    <= '0;
      wr_pulse  <= '0;
      rd_pulse  <= '0;
      regs.reg0 <= reg0ResetVal;
      regs.reg1 <= reg1ResetVal;
      regs.reg2 <= reg2ResetVal;
      regs.reg3 <= reg3ResetVal;
      regs.reg4 <= reg4ResetVal;
      regs.reg7 <= reg7ResetVal;
    end else begin
      state     <= stateNext;
      waitCnt   <= waitCntNext;
      reqAddr   <= reqAddrNext;
      reqWrite  <= reqWriteNext;
      reqWdata  <= reqWdataNext;
      reqStrb   <= reqStrbNext;
      pready    <= preadyNext;
      prdata    <= prdataNext;
      wr_pulse  <= wrPulseNext;
      rd_pulse  <= rdPulseNext;
      regs      <= regsNext;
    end
  end
endmodule

// File: tb/tb_example_apb_regs.sv
// tb/tb_example_apb_regs.sv - scoreboard bench for example_apb_regs
module tb_example_apb_regs;
  import example_sv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               psel [3];
  logic               penable [3];
  logic               pwrite [3];
  logic [4:0]         paddr [3];
  logic [31:0]        pwdata [3];
  logic [3:0]         pstrb [3];
  logic [31:0]        prdata [3];
  logic               pready [3];
  logic               pslverr [3];
  example_struct_type regsOut [3];
  logic [7:0]         wrP [3];
  logic [7:0]         rdP [3];
  logic               hwWe [3];
  logic [31:0]        hwData [3];

  example_apb_regs #(.WAIT_STATES(1)) dut0 (
    .clk(clk), .reset(reset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .regs(regsOut[0]), .wr_pulse(wrP[0]),
    .rd_pulse(rdP[0]), .hw_reg6_we(hwWe[0]), .hw_reg6_data(hwData[0]));
  example_apb_regs #(.WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(reset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .regs(regsOut[1]), .wr_pulse(wrP[1]),
    .rd_pulse(rdP[1]), .hw_reg6_we(hwWe[1]), .hw_reg6_data(hwData[1]));
  example_apb_regs #(.WAIT_STATES(3)) dut2 (
    .clk(clk), .reset(reset), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
    .paddr(paddr[2]), .pwdata(pwdata[2]), .pstrb(pstrb[2]), .prdata(prdata[2]),
    .pready(pready[2]), .pslverr(pslverr[2]), .regs(regsOut[2]), .wr_pulse(wrP[2]),
    .rd_pulse(rdP[2]), .hw_reg6_we(hwWe[2]), .hw_reg6_data(hwData[2]));

  typedef struct {
    bit          isWrite;
    logic [31:0] data;
    logic [7:0]  pulse;
    int          setupCycle;
    int          latency;
    bit          chkSpacing;
    int          spacing;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  item_t q2[$];

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int wsOf [3] = '{1, 0, 3};
  int lastReady [3] = '{0, 0, 0};
  bit pendChk [3] = '{0, 0, 0};
  logic [7:0] expWr [3];
  logic [7:0] expRd [3];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cycle=%0d: got %h want %h", nm, inst, cycle, act, exp);
    end
  endtask

  task automatic pushItem(input int i, input item_t it);
    case (i)
      0: q0.push_back(it);
      1: q1.push_back(it);
      default: q2.push_back(it);
    endcase
  endtask

  // Monitor: pops the scoreboard on every pready and checks the pulses one cycle later.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pendChk[i]) begin
        chk("wr_pulse", i, 32'(wrP[i]), 32'(expWr[i]));
        chk("rd_pulse", i, 32'(rdP[i]), 32'(expRd[i]));
        pendChk[i] = 1'b0;
      end
      if (pready[i] === 1'b1) begin
        item_t it;
        bit got;
        got = 1'b0;
        case (i)
          0: if (q0.size() > 0) begin it = q0.pop_front(); got = 1'b1; end
          1: if (q1.size() > 0) begin it = q1.pop_front(); got = 1'b1; end
          default: if (q2.size() > 0) begin it = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
          total++;
          bad++;
          $display("FAIL unexpected_pready inst=%0d cycle=%0d: got pready=1 want 0", i, cycle);
        end else begin
          if (it.isWrite) chk("prdata_on_write", i, prdata[i], 32'd0);
          else            chk("prdata", i, prdata[i], it.data);
          chk("pslverr", i, 32'(pslverr[i]), 32'd0);
          chk("latency", i, cycle - it.setupCycle, it.latency);
          if (it.chkSpacing) chk("spacing", i, cycle - lastReady[i], it.spacing);
          expWr[i]   = it.isWrite ? it.pulse : 8'h00;
          expRd[i]   = it.isWrite ? 8'h00 : it.pulse;
          pendChk[i] = 1'b1;
        end
        lastReady[i] = cycle;
      end
    end
  end

  task automatic setupPhase(input int i, input logic w, input logic [2:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    psel[i]    = 1'b1;
    penable[i] = 1'b0;
    pwrite[i]  = w;
    paddr[i]   = {a, 2'b00};
    pwdata[i]  = d;
    pstrb[i]   = s;
  endtask

  task automatic waitReady(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (pready[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL timeout inst=%0d: got no pready want pready within 20 cycles", i);
    end
  endtask

  task automatic xfer(input int i, input logic w, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] expd, input bit coll,
                      input logic [31:0] hwd);
    item_t it;
    bit ok;
    it.isWrite    = w;
    it.data       = expd;
    it.pulse      = 8'b1 << a;
    it.setupCycle = cycle;
    it.latency    = 2 + wsOf[i];
    it.chkSpacing = 1'b0;
    it.spacing    = 0;
    pushItem(i, it);
    setupPhase(i, w, a, d, s);
    @(posedge clk); #1 penable[i] = 1'b1;
    waitReady(i, ok);
    if (coll) begin
      hwWe[i]   = 1'b1;
      hwData[i] = hwd;
    end
    psel[i]    = 1'b0;
    penable[i] = 1'b0;
    @(posedge clk); #1 hwWe[i] = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    xfer(0, 1'b1, a, d, s, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    xfer(0, 1'b0, a, 32'd0, 4'd0, e, 1'b0, 32'd0);
  endtask

  // Four reads of addresses 0..3, each next SETUP driven in the current pready cycle.
  task automatic b2b(input int i);
    logic [31:0] e [4];
    item_t it;
    bit ok;
    e = '{32'h0, 32'h1, 32'h1, 32'h1};
    it.isWrite    = 1'b0;
    it.data       = e[0];
    it.pulse      = 8'h01;
    it.setupCycle = cycle;
    it.latency    = 2 + wsOf[i];
    it.chkSpacing = 1'b0;
    it.spacing    = 2 + wsOf[i];
    pushItem(i, it);
    setupPhase(i, 1'b0, 3'd0, 32'd0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 penable[i] = 1'b1;
      waitReady(i, ok);
      if (!ok) break;
      if (k < 3) begin
        it.data       = e[k+1];
        it.pulse      = 8'b1 << (k + 1);
        it.setupCycle = cycle;
        it.chkSpacing = 1'b1;
        pushItem(i, it);
        setupPhase(i, 1'b0, 3'(k + 1), 32'd0, 4'd0);
      end
    end
    psel[i]    = 1'b0;
    penable[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic resetPulse();
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0;
      pwdata[i] = '0; pstrb[i] = '0; hwWe[i] = 1'b0; hwData[i] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk("reset_pready", i, 32'(pready[i]), 32'd0);
      chk("reset_prdata", i, prdata[i], 32'd0);
      chk("reset_wr_pulse", i, 32'(wrP[i]), 32'd0);
      chk("reset_rd_pulse", i, 32'(rdP[i]), 32'd0);
    end

    rd(3'd0, 32'h0);
    rd(3'd1, 32'h1);
    rd(3'd2, 32'h1);
    rd(3'd3, 32'h1);
    rd(3'd4, 32'hC);
    rd(3'd7, 32'h0);

    wr(3'd0, 32'hDEADBEEF, 4'hF);
    chk("regs_reg0", 0, regsOut[0].reg0, 32'hDEADBEEF);
    rd(3'd0, 32'hDEADBEEF);
    wr(3'd2, 32'hFFFFFFFF, 4'hF);
    rd(3'd2, 32'h0000003F);

    wr(3'd1, 32'h11223344, 4'h5);
    rd(3'd1, 32'h00220044);
    wr(3'd1, 32'hFFFFFFFF, 4'h0);
    rd(3'd1, 32'h00220044);

    wr(3'd4, 32'h3, 4'hF);
    wr(3'd5, 32'hA5A5A5A5, 4'hF);
    resetPulse();
    rd(3'd5, 32'hA5A5A5A5);
    rd(3'd4, 32'hC);

    hwWe[0] = 1'b1;
    hwData[0] = 32'h12345678;
    @(posedge clk); #1 hwWe[0] = 1'b0;
    rd(3'd6, 32'h12345678);
    xfer(0, 1'b1, 3'd6, 32'hCAFEF00D, 4'hF, 32'd0, 1'b1, 32'h0);
    rd(3'd6, 32'hCAFEF00D);

    // Reset lands in the first ACCESS cycle of a write to reg3.
    setupPhase(0, 1'b1, 3'd3, 32'h7, 4'hF);
    @(posedge clk); #1 penable[0] = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_pready", 0, 32'(pready[0]), 32'd0);
    psel[0] = 1'b0;
    penable[0] = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_wr_pulse", 0, 32'(wrP[0]), 32'd0);
    rd(3'd3, 32'h1);

    b2b(1);
    b2b(2);

    repeat (3) @(posedge clk);
    #1 chk("queues_empty", 0, q0.size() + q1.size() + q2.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
